// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage: function codes, FSM states
// and the decode helpers used to tell single-, dual-write and illegal entries apart.
package alu_wb_pkg;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] MUL = 4'b0100;
    localparam logic [3:0] DIV = 4'b0101;
    localparam logic [3:0] MOV = 4'b0111;
    localparam logic [3:0] SWP = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        W1,
        W2
    } wb_state_e;

    function automatic logic is_dual(input logic [3:0] code);
        return (code == MUL) || (code == DIV) || (code == SWP);
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        return (code == ADD) || (code == SUB) || (code == MOV) || is_dual(code);
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Small synchronous FIFO that buffers ALU entries ahead of the writeback FSM.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_wb_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= din;
    end

    assign head  = mem_q[rdPtr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: retires buffered ALU entries through one register-file
// write port. Define ALU_WB_STATS_EN to add the saturating retired_cnt output.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        functCode,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] remainder,
    input  logic              o,
    input  logic [ADDR_W-1:0] dest_a,
    input  logic [ADDR_W-1:0] dest_b,
    input  logic              clr_flags,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              ovf_flag,
    output logic              ill_flag
`ifdef ALU_WB_STATS_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    localparam int ENTRY_W = 4 + 2 * DATA_W + 1 + 2 * ADDR_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    wb_state_e          state_q, state_d;
    logic               wrEn_q, wrEn_d;
    logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0]  wrData_q, wrData_d;
    logic               ovfFlag_q, ovfFlag_d;
    logic               illFlag_q, illFlag_d;

    logic               push, pop, retire;
    logic               fifoFull, fifoEmpty, moreAvail;
    logic [CNT_W-1:0]   fifoCount;
    logic [ENTRY_W-1:0] headEntry;
    logic [3:0]         hCode;
    logic [DATA_W-1:0]  hResult, hRem;
    logic               hO;
    logic [ADDR_W-1:0]  hDestA, hDestB;

    assign in_ready = !fifoFull;
    assign push     = in_valid && in_ready;

    alu_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({functCode, result, remainder, o, dest_a, dest_b}),
        .head  (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign {hCode, hResult, hRem, hO, hDestA, hDestB} = headEntry;

    // After popping the head, another entry is present if one was queued behind it or is arriving now.
    assign moreAvail = (fifoCount > CNT_W'(1)) || push;

    always_comb begin
        state_d  = state_q;
        wrEn_d   = 1'b0;
        wrAddr_d = wrAddr_q;
        wrData_d = wrData_q;
        pop      = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) state_d = W1;
            end
            W1: begin
                if (is_legal(hCode)) begin
                    wrEn_d   = 1'b1;
                    wrAddr_d = (hCode == SWP) ? hDestB : hDestA;
                    wrData_d = hResult;
                end
                if (is_legal(hCode) && is_dual(hCode)) begin
                    state_d = W2;
                end else begin
                    pop     = 1'b1;
                    retire  = 1'b1;
                    state_d = moreAvail ? W1 : IDLE;
                end
            end
            W2: begin
                wrEn_d   = 1'b1;
                wrAddr_d = (hCode == SWP) ? hDestA : hDestB;
                wrData_d = hRem;
                pop      = 1'b1;
                retire   = 1'b1;
                state_d  = moreAvail ? W1 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A retiring entry sets its sticky bits even when a clear is requested.
        ovfFlag_d = ovfFlag_q;
        illFlag_d = illFlag_q;
        if (clr_flags) begin
            ovfFlag_d = 1'b0;
            illFlag_d = 1'b0;
        end
        if (retire && hO)              ovfFlag_d = 1'b1;
        if (retire && !is_legal(hCode)) illFlag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wrEn_q    <= 1'b0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            ovfFlag_q <= 1'b0;
            illFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            ovfFlag_q <= ovfFlag_d;
            illFlag_q <= illFlag_d;
        end
    end

    assign wr_en    = wrEn_q;
    assign wr_addr  = wrAddr_q;
    assign wr_data  = wrData_q;
    assign ovf_flag = ovfFlag_q;
    assign ill_flag = illFlag_q;
    assign busy     = !fifoEmpty || (state_q != IDLE);

`ifdef ALU_WB_STATS_EN
    logic [15:0] retiredCnt_q, retiredCnt_d;

    always_comb begin
        retiredCnt_d = retiredCnt_q;
        if (retire) begin
            if (retiredCnt_q != 16'hFFFF) retiredCnt_d = retiredCnt_q + 16'd1;
        end else if (clr_flags) begin
            retiredCnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retiredCnt_q <= '0;
        else      retiredCnt_q <= retiredCnt_d;
    end

    assign retired_cnt = retiredCnt_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: a vector table of single entries pushed
// into an idle block, plus hand-written back-to-back, flag-race and reset sequences.
module tb_alu_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  functCode;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        o;
    logic [3:0]  dest_a;
    logic [3:0]  dest_b;
    logic        clr_flags;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        ovf_flag;
    logic        ill_flag;
`ifdef ALU_WB_STATS_EN
    logic [15:0] retired_cnt;
`endif

    alu_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .functCode (functCode),
        .result    (result),
        .remainder (remainder),
        .o         (o),
        .dest_a    (dest_a),
        .dest_b    (dest_b),
        .clr_flags (clr_flags),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .ovf_flag  (ovf_flag),
        .ill_flag  (ill_flag)
`ifdef ALU_WB_STATS_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] res;
        logic [15:0] rem;
        logic        ov;
        logic [3:0]  da;
        logic [3:0]  db;
        int          nWr;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic [3:0]  a2;
        logic [15:0] d2;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    // Every write strobe seen while out of reset, as {addr, data}.
    logic [19:0] writeLog[$];

    always @(posedge clk) begin
        #1;
        if (rst && wr_en) writeLog.push_back({wr_addr, wr_data});
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the entry is pushed at the next rising edge.
    task automatic applyStimulus(input logic [3:0] code, input logic [15:0] res, input logic [15:0] rem,
                                 input logic ov, input logic [3:0] da, input logic [3:0] db);
        in_valid  = 1'b1;
        functCode = code;
        result    = res;
        remainder = rem;
        o         = ov;
        dest_a    = da;
        dest_b    = db;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic clearFlags();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int c = 0;
        while (busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        checkOutput($sformatf("%s idle", name), {31'd0, busy}, 32'd0);
    endtask

    task automatic checkLog(input string name, input logic [19:0] exp[$]);
        checkOutput($sformatf("%s write count", name), writeLog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < writeLog.size(); i++)
            checkOutput($sformatf("%s write %0d", name, i), {12'd0, writeLog[i]}, {12'd0, exp[i]});
    endtask

    initial begin
        logic [19:0] expLog[$];
        logic        acc;
        logic        sawNotReady;
        int          k;
        int          cyc;

        vecs[0] = '{4'h0, 16'h9999, 16'h0000, 1'b0, 4'd3,  4'd0, 1, 4'd3,  16'h9999, 4'd0, 16'h0000, 1'b0};
        vecs[1] = '{4'h4, 16'h0003, 16'h0001, 1'b0, 4'd1,  4'd2, 2, 4'd1,  16'h0003, 4'd2, 16'h0001, 1'b0};
        vecs[2] = '{4'h8, 16'h1111, 16'h8888, 1'b0, 4'd4,  4'd5, 2, 4'd5,  16'h1111, 4'd4, 16'h8888, 1'b0};
        vecs[3] = '{4'h1, 16'h1234, 16'h0000, 1'b1, 4'd7,  4'd0, 1, 4'd7,  16'h1234, 4'd0, 16'h0000, 1'b0};
        vecs[4] = '{4'h7, 16'hBEEF, 16'h0000, 1'b0, 4'd15, 4'd0, 1, 4'd15, 16'hBEEF, 4'd0, 16'h0000, 1'b0};
        vecs[5] = '{4'h5, 16'h0005, 16'h0002, 1'b0, 4'd6,  4'd6, 2, 4'd6,  16'h0005, 4'd6, 16'h0002, 1'b0};
        vecs[6] = '{4'hF, 16'hABCD, 16'h0000, 1'b0, 4'd8,  4'd9, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 1'b1};
        vecs[7] = '{4'h2, 16'h5555, 16'h0000, 1'b1, 4'd2,  4'd3, 0, 4'd0,  16'h0000, 4'd0, 16'h0000, 1'b1};

        rst       = 1'b0;
        in_valid  = 1'b0;
        functCode = 4'h0;
        result    = '0;
        remainder = '0;
        o         = 1'b0;
        dest_a    = '0;
        dest_b    = '0;
        clr_flags = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset wr_en",   {31'd0, wr_en},    32'd0);
        checkOutput("reset wr_addr", {28'd0, wr_addr},  32'd0);
        checkOutput("reset wr_data", {16'd0, wr_data},  32'd0);
        checkOutput("reset ovf",     {31'd0, ovf_flag}, 32'd0);
        checkOutput("reset ill",     {31'd0, ill_flag}, 32'd0);
        checkOutput("reset busy",    {31'd0, busy},     32'd0);
`ifdef ALU_WB_STATS_EN
        checkOutput("reset retired_cnt", {16'd0, retired_cnt}, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);

        // Single entries into an idle block: first write appears after edge N+2.
        for (int i = 0; i < 8; i++) begin
            clearFlags();
            applyStimulus(vecs[i].code, vecs[i].res, vecs[i].rem, vecs[i].ov, vecs[i].da, vecs[i].db);
            checkOutput($sformatf("v%0d busy after push", i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("v%0d wr_en at N", i), {31'd0, wr_en}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d wr_en at N+1", i), {31'd0, wr_en}, 32'd0);
            @(negedge clk);
            if (vecs[i].nWr > 0) begin
                checkOutput($sformatf("v%0d wr1 en", i),   {31'd0, wr_en},   32'd1);
                checkOutput($sformatf("v%0d wr1 addr", i), {28'd0, wr_addr}, {28'd0, vecs[i].a1});
                checkOutput($sformatf("v%0d wr1 data", i), {16'd0, wr_data}, {16'd0, vecs[i].d1});
            end else begin
                checkOutput($sformatf("v%0d no write", i), {31'd0, wr_en}, 32'd0);
            end
            if (vecs[i].nWr == 2) begin
                @(negedge clk);
                checkOutput($sformatf("v%0d wr2 en", i),   {31'd0, wr_en},   32'd1);
                checkOutput($sformatf("v%0d wr2 addr", i), {28'd0, wr_addr}, {28'd0, vecs[i].a2});
                checkOutput($sformatf("v%0d wr2 data", i), {16'd0, wr_data}, {16'd0, vecs[i].d2});
            end
            @(negedge clk);
            checkOutput($sformatf("v%0d wr_en done", i), {31'd0, wr_en},    32'd0);
            checkOutput($sformatf("v%0d busy done", i),  {31'd0, busy},     32'd0);
            checkOutput($sformatf("v%0d ovf", i),        {31'd0, ovf_flag}, {31'd0, vecs[i].ov});
            checkOutput($sformatf("v%0d ill", i),        {31'd0, ill_flag}, {31'd0, vecs[i].ill});
        end

        // Swap immediately followed by an illegal code.
        clearFlags();
        writeLog.delete();
        in_valid  = 1'b1;
        functCode = 4'h8; result = 16'h1111; remainder = 16'h8888; o = 1'b0; dest_a = 4'd4; dest_b = 4'd5;
        @(negedge clk);
        functCode = 4'hF; result = 16'h2222; remainder = 16'h3333; dest_a = 4'd6; dest_b = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        waitIdle("swap+illegal");
        expLog = '{{4'd5, 16'h1111}, {4'd4, 16'h8888}};
        checkLog("swap+illegal", expLog);
        checkOutput("swap+illegal ill", {31'd0, ill_flag}, 32'd1);

        // Three back-to-back divides against a two-entry FIFO.
        clearFlags();
        writeLog.delete();
        sawNotReady = 1'b0;
        k   = 0;
        cyc = 0;
        in_valid  = 1'b1;
        functCode = 4'h5; o = 1'b0;
        result = 16'h0010; remainder = 16'h0001; dest_a = 4'd1; dest_b = 4'd2;
        while (k < 3 && cyc < 40) begin
            acc = in_ready;
            if (!acc) sawNotReady = 1'b1;
            @(negedge clk);
            cyc++;
            if (acc) begin
                k++;
                result    = 16'h0010 * 16'(k + 1);
                remainder = 16'(k + 1);
                dest_a    = 4'(2 * k + 1);
                dest_b    = 4'(2 * k + 2);
            end
        end
        in_valid = 1'b0;
        checkOutput("burst accepted", k, 3);
        checkOutput("burst in_ready dropped", {31'd0, sawNotReady}, 32'd1);
        waitIdle("burst");
        expLog = '{{4'd1, 16'h0010}, {4'd2, 16'h0001}, {4'd3, 16'h0020},
                   {4'd4, 16'h0002}, {4'd5, 16'h0030}, {4'd6, 16'h0003}};
        checkLog("burst", expLog);

        // Overflow retiring in the same cycle as a clear: the set wins.
        clearFlags();
        applyStimulus(4'h0, 16'h0042, 16'h0000, 1'b1, 4'd9, 4'd0);
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        checkOutput("ovf race wr_en", {31'd0, wr_en},    32'd1);
        checkOutput("ovf set wins",   {31'd0, ovf_flag}, 32'd1);
        @(negedge clk);
        checkOutput("ovf cleared",    {31'd0, ovf_flag}, 32'd0);
        clr_flags = 1'b0;

        // Reset asserted while the second write of a divide is pending.
        clearFlags();
        applyStimulus(4'h5, 16'h0007, 16'h0003, 1'b0, 4'd10, 4'd11);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst-mid first write en",   {31'd0, wr_en},   32'd1);
        checkOutput("rst-mid first write addr", {28'd0, wr_addr}, 32'd10);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst-mid wr_en",    {31'd0, wr_en},    32'd0);
        checkOutput("rst-mid busy",     {31'd0, busy},     32'd0);
        checkOutput("rst-mid in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst-mid wr_addr",  {28'd0, wr_addr},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        writeLog.delete();
        repeat (4) @(negedge clk);
        checkOutput("after rst no writes", writeLog.size(), 0);
        checkOutput("after rst busy",      {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
